// File: rtl/bsg_mem_1r1w_sync_reader.sv
// bsg_mem_1r1w_sync_reader
//
// Initiator-side adapter for a 1r1w synchronous memory with a fixed 1-cycle
// read latency. It turns a valid/ready read-request stream and an always-
// accepted write stream into memory strobes. Returned read data is captured
// in a small response FIFO, which is presented on a valid/yumi channel.
// Same-address read/write collisions either stall the read for a cycle or
// forward the write data to the read, so the client never sees undefined data.
//
// Optional feature macro: BSG_MEM_1R1W_SYNC_READER_FWD_EN
//   defined   : a colliding read is accepted and the write data is forwarded
//   undefined : a colliding read is refused (r_ready_o=0) and retries
//
// Ports
//   clk_i, reset_n_i             clock, asynchronous active-low reset
//   r_v_i, r_addr_i, r_ready_o   read request stream (valid/ready)
//   w_v_i, w_addr_i, w_data_i    write stream (always accepted)
//   data_o, v_o, yumi_i          response stream (valid/yumi)
//   mem_w_v_o, mem_w_addr_o,
//   mem_w_data_o                 memory write port
//   mem_r_v_o, mem_r_addr_o      memory read port request
//   mem_r_data_i                 memory read data, valid the cycle after mem_r_v_o
module bsg_mem_1r1w_sync_reader #(
  parameter int width_p                = 8,
  parameter int els_p                  = 16,
  parameter int fifo_els_p             = 3,
  parameter int read_write_same_addr_p = 0,
  parameter int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic                     r_ready_o,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  output logic [width_p-1:0]       data_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic                     mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     mem_r_v_o,
  output logic [addr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p-1:0]       mem_r_data_i
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(fifo_els_p - 1);
  localparam logic [cnt_w_lp:0]   fifo_els_lp = (cnt_w_lp + 1)'(fifo_els_p);

  logic                 r_inflight;
  logic [ptr_w_lp-1:0]  r_wptr;
  logic [ptr_w_lp-1:0]  r_rptr;
  logic [cnt_w_lp-1:0]  r_cnt;
  logic [width_p-1:0]   r_fifo [fifo_els_p];

  logic                 w_coll;
  logic                 w_coll_block;
  logic                 w_fwd_sel;
  logic [width_p-1:0]   w_fwd_data;
  logic [cnt_w_lp:0]    w_occ;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [width_p-1:0]   w_push_data;

  // A memory that defines same-cycle same-address behaviour (read-old) needs
  // no collision handling at all.
  assign w_coll = w_v_i & r_v_i & (w_addr_i == r_addr_i)
                & (read_write_same_addr_p == 0);

`ifdef BSG_MEM_1R1W_SYNC_READER_FWD_EN
  logic               r_fwd_v;
  logic [width_p-1:0] r_fwd_data;

  // Capture the colliding write so the next-cycle push can bypass the
  // memory's undefined read data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fwd_v    <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_v <= w_accept & w_coll;
      if (w_accept & w_coll)
        r_fwd_data <= w_data_i;
    end
  end

  assign w_coll_block = 1'b0;
  assign w_fwd_sel    = r_fwd_v;
  assign w_fwd_data   = r_fwd_data;
`else
  assign w_coll_block = w_coll;
  assign w_fwd_sel    = 1'b0;
  assign w_fwd_data   = '0;
`endif

  // Reserve a FIFO slot for every read still in the memory pipe. Only
  // registered state feeds this, so yumi_i and mem_r_data_i never reach
  // r_ready_o combinationally.
  assign w_occ     = (cnt_w_lp + 1)'(r_cnt) + (cnt_w_lp + 1)'(r_inflight);
  assign r_ready_o = reset_n_i & (w_occ < fifo_els_lp) & ~w_coll_block;
  assign w_accept  = r_v_i & r_ready_o;

  assign mem_r_v_o    = w_accept;
  assign mem_r_addr_o = r_addr_i;

  assign mem_w_v_o    = w_v_i & reset_n_i;
  assign mem_w_addr_o = w_addr_i;
  assign mem_w_data_o = w_data_i;

  assign w_push      = r_inflight;
  assign w_push_data = w_fwd_sel ? w_fwd_data : mem_r_data_i;
  // An illegal yumi with an empty FIFO must not disturb the pointers.
  assign w_pop       = yumi_i & v_o;

  assign v_o    = (r_cnt != '0);
  assign data_o = v_o ? r_fifo[r_rptr] : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_push)
        r_wptr <= (r_wptr == last_ptr_lp) ? '0 : r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= (r_rptr == last_ptr_lp) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage holds no reset; v_o gates data_o while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push)
      r_fifo[r_wptr] <= w_push_data;
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i)
      assert (!(yumi_i && !v_o))
        else $error("bsg_mem_1r1w_sync_reader: yumi_i asserted while v_o=0");
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_reader.sv
// Directed testbench for bsg_mem_1r1w_sync_reader with a behavioural
// read-old 1r1w synchronous memory attached.
module tb_bsg_mem_1r1w_sync_reader;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk_i;
  logic          reset_n_i;
  logic          r_v_i;
  logic [AW-1:0] r_addr_i;
  logic          r_ready_o;
  logic          w_v_i;
  logic [AW-1:0] w_addr_i;
  logic [W-1:0]  w_data_i;
  logic [W-1:0]  data_o;
  logic          v_o;
  logic          yumi_i;
  logic          yumi_en;
  logic          mem_w_v_o;
  logic [AW-1:0] mem_w_addr_o;
  logic [W-1:0]  mem_w_data_o;
  logic          mem_r_v_o;
  logic [AW-1:0] mem_r_addr_o;
  logic [W-1:0]  mem_r_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mem_model [16];

  bsg_mem_1r1w_sync_reader #(
    .width_p(W), .els_p(16), .fifo_els_p(3), .read_write_same_addr_p(0)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_ready_o(r_ready_o),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
    .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_r_v_o(mem_r_v_o), .mem_r_addr_o(mem_r_addr_o), .mem_r_data_i(mem_r_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Consumer is always ready when enabled, but only ever yumis a valid response.
  assign yumi_i = yumi_en & v_o;

  // Read-old synchronous memory: both updates are nonblocking, so a same-cycle
  // read of a written address returns the previous contents.
  always @(posedge clk_i) begin
    if (mem_w_v_o) mem_model[mem_w_addr_o] <= mem_w_data_o;
    if (mem_r_v_o) mem_r_data_i <= mem_model[mem_r_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %s ok: %0h", tag, obs);
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // ---- 1: reset, with requests pending to prove they are masked ----
    reset_n_i = 1'b0;
    yumi_en   = 1'b0;
    r_v_i = 1'b1; r_addr_i = 4'd5;
    w_v_i = 1'b1; w_addr_i = 4'd5; w_data_i = 8'h55;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_v_o", 32'(v_o), 32'd0);
    chk("rst_r_ready", 32'(r_ready_o), 32'd0);
    chk("rst_mem_r_v", 32'(mem_r_v_o), 32'd0);
    chk("rst_mem_w_v", 32'(mem_w_v_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    reset_n_i = 1'b1;
    r_v_i = 1'b0; w_v_i = 1'b0;
    tick();

    // ---- 2: write 5=A5, read it back, latency 2 ----
    w_v_i = 1'b1; w_addr_i = 4'd5; w_data_i = 8'hA5;
    #1;
    chk("t2_mem_w_v", 32'(mem_w_v_o), 32'd1);
    chk("t2_mem_w_addr", 32'(mem_w_addr_o), 32'd5);
    chk("t2_mem_w_data", 32'(mem_w_data_o), 32'hA5);
    tick();
    w_v_i = 1'b0; r_v_i = 1'b1; r_addr_i = 4'd5; yumi_en = 1'b1;
    #1;
    chk("t2_r_ready", 32'(r_ready_o), 32'd1);
    chk("t2_mem_r_v", 32'(mem_r_v_o), 32'd1);
    chk("t2_mem_r_addr", 32'(mem_r_addr_o), 32'd5);
    tick();
    r_v_i = 1'b0;
    #1;
    chk("t2_v_o_lat1", 32'(v_o), 32'd0);
    tick();
    chk("t2_v_o_lat2", 32'(v_o), 32'd1);
    chk("t2_data", 32'(data_o), 32'hA5);
    tick();
    chk("t2_v_o_after", 32'(v_o), 32'd0);

    // ---- 3: back-to-back reads of addr*3 ----
    for (int a = 0; a < 10; a++) begin
      w_v_i = 1'b1; w_addr_i = 4'(a); w_data_i = 8'(a * 3);
      tick();
    end
    w_v_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      r_v_i = (i < 10); r_addr_i = 4'(i);
      #1;
      if (i < 10) chk($sformatf("t3_r_ready_%0d", i), 32'(r_ready_o), 32'd1);
      if (i >= 2) begin
        chk($sformatf("t3_v_o_%0d", i), 32'(v_o), 32'd1);
        chk($sformatf("t3_data_%0d", i), 32'(data_o), 32'((i - 2) * 3));
      end
      tick();
    end
    r_v_i = 1'b0;
    #1;
    chk("t3_drained", 32'(v_o), 32'd0);

    // ---- 4: backpressure, 5 requests, only 3 fit ----
    yumi_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_v_i = 1'b1; r_addr_i = 4'(i);
      #1;
      chk($sformatf("t4_accept_%0d", i), 32'(r_ready_o), 32'd1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      r_v_i = 1'b1; r_addr_i = 4'd3;
      #1;
      chk($sformatf("t4_stall_%0d", i), 32'(r_ready_o), 32'd0);
      chk($sformatf("t4_stall_memrv_%0d", i), 32'(mem_r_v_o), 32'd0);
      tick();
    end
    chk("t4_full_v_o", 32'(v_o), 32'd1);
    chk("t4_full_head", 32'(data_o), 32'd0);
    yumi_en = 1'b1;
    // cycle 0: pop of entry 0 only, no slot freed yet
    r_v_i = 1'b1; r_addr_i = 4'd3; #1;
    chk("t4_c0_ready", 32'(r_ready_o), 32'd0);
    chk("t4_c0_data", 32'(data_o), 32'd0);
    tick();
    r_addr_i = 4'd3; #1;
    chk("t4_c1_ready", 32'(r_ready_o), 32'd1);
    chk("t4_c1_data", 32'(data_o), 32'd3);
    tick();
    r_addr_i = 4'd4; #1;
    chk("t4_c2_ready", 32'(r_ready_o), 32'd1);
    chk("t4_c2_data", 32'(data_o), 32'd6);
    tick();
    r_v_i = 1'b0; #1;
    chk("t4_c3_data", 32'(data_o), 32'd9);
    tick();
    chk("t4_c4_v_o", 32'(v_o), 32'd1);
    chk("t4_c4_data", 32'(data_o), 32'd12);
    tick();
    chk("t4_drained", 32'(v_o), 32'd0);

    // ---- 5: same-cycle write and read of address 7 ----
    w_v_i = 1'b1; w_addr_i = 4'd7; w_data_i = 8'h11;
    tick();
    w_v_i = 1'b1; w_addr_i = 4'd7; w_data_i = 8'h3C;
    r_v_i = 1'b1; r_addr_i = 4'd7;
    #1;
    chk("t5_mem_w_v", 32'(mem_w_v_o), 32'd1);
`ifdef BSG_MEM_1R1W_SYNC_READER_FWD_EN
    chk("t5_fwd_ready", 32'(r_ready_o), 32'd1);
    chk("t5_fwd_mem_r_v", 32'(mem_r_v_o), 32'd1);
    tick();
    w_v_i = 1'b0; r_v_i = 1'b0;
`else
    chk("t5_coll_ready", 32'(r_ready_o), 32'd0);
    chk("t5_coll_mem_r_v", 32'(mem_r_v_o), 32'd0);
    tick();
    w_v_i = 1'b0;
    #1;
    chk("t5_retry_ready", 32'(r_ready_o), 32'd1);
    chk("t5_retry_mem_r_v", 32'(mem_r_v_o), 32'd1);
    tick();
    r_v_i = 1'b0;
`endif
    #1;
    chk("t5_v_o_lat1", 32'(v_o), 32'd0);
    tick();
    chk("t5_v_o", 32'(v_o), 32'd1);
    chk("t5_data", 32'(data_o), 32'h3C);
    tick();
    chk("t5_drained", 32'(v_o), 32'd0);

    // ---- 6: reset with 1 inflight + 2 buffered ----
    yumi_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_v_i = 1'b1; r_addr_i = 4'(i);
      #1;
      chk($sformatf("t6_accept_%0d", i), 32'(r_ready_o), 32'd1);
      tick();
    end
    r_addr_i = 4'd3;
    #1;
    chk("t6_pre_v_o", 32'(v_o), 32'd1);
    chk("t6_pre_ready", 32'(r_ready_o), 32'd0);
    reset_n_i = 1'b0;
    #1;
    chk("t6_rst_v_o", 32'(v_o), 32'd0);
    chk("t6_rst_data", 32'(data_o), 32'd0);
    chk("t6_rst_mem_r_v", 32'(mem_r_v_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;
    r_v_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_post_v_o_%0d", i), 32'(v_o), 32'd0);
      tick();
    end
    yumi_en = 1'b1;
    r_v_i = 1'b1; r_addr_i = 4'd7;
    #1;
    chk("t6_new_ready", 32'(r_ready_o), 32'd1);
    tick();
    r_v_i = 1'b0;
    #1;
    chk("t6_new_lat1", 32'(v_o), 32'd0);
    tick();
    chk("t6_new_v_o", 32'(v_o), 32'd1);
    chk("t6_new_data", 32'(data_o), 32'h3C);
    tick();
    chk("t6_new_drained", 32'(v_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
